// File: rtl/attr_pkg.sv
// Shared constants, sideband bundle and DAC index composition
// for the attribute-controller pixel pipeline.
package attr_pkg;

    localparam int ATTR_IDX_W      = 4;
    localparam int PAL_W           = 6;
    localparam int DAC_W           = 8;
    localparam int BLINK_CTR_W     = 5;
    localparam int ATTR_PIPE_DEPTH = 3;

    typedef struct packed {
        logic valid;
        logic de;
        logic phase;
    } attr_sb_t;

    // 16-colour path: colour-select supplies the top bits, and with
    // p54s set it also overrides palette bits 5:4.
    function automatic logic [DAC_W-1:0] dac_compose(
        input logic [ATTR_IDX_W-1:0] cs,
        input logic                  p54s,
        input logic [PAL_W-1:0]      pal
    );
        logic [1:0] mid;
        mid = p54s ? cs[1:0] : pal[5:4];
        return {cs[3:2], mid, pal[3:0]};
    endfunction

endpackage

// File: rtl/attr_blink_ctr.sv
// Blink frame counter: registered vsync edge detect plus a 5-bit
// wrapping frame counter; blink_phase is counter bit 4.
// Ports: clk, rst (async high), vsync in; blink_phase out.
// Built only when ATTR_BLINK_EN is defined.
`ifdef ATTR_BLINK_EN
module attr_blink_ctr
    import attr_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic blink_phase
);

    logic                   vsync_q;
    logic                   rise;
    logic [BLINK_CTR_W-1:0] ctr;
    logic [BLINK_CTR_W-1:0] ctr_inc;

    assign rise    = vsync & ~vsync_q;
    assign ctr_inc = ctr + BLINK_CTR_W'(1);

    // Runs every clk, independent of the pixel-rate enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q <= 1'b0;
            ctr     <= '0;
        end else begin
            vsync_q <= vsync;
            if (rise)
                ctr <= ctr_inc;
        end
    end

    // A pixel accepted in the same cycle as the vsync edge already
    // sees the incremented count.
    assign blink_phase = rise ? ctr_inc[BLINK_CTR_W-1]
                              : ctr[BLINK_CTR_W-1];

endmodule
`endif

// File: rtl/attr_pixel_pipe.sv
// Attribute-controller pixel pipeline: plane mask + blink, palette
// read, colour-select/overscan merge into the 8-bit DAC index.
// Ports: clk, h_reset (async high), clk_en; pixel in (pix_valid,
// pix_idx, pix_de, pix_blink); vsync; mode regs (plane_en,
// mode_8bpp, p54s, blink_en, color_sel, overscan); palette port
// (pal_addr out, pal_data in); dac_idx, dac_valid out.
// Macro ATTR_BLINK_EN builds the blink counter and blink masking.
module attr_pixel_pipe
    import attr_pkg::*;
#(
    parameter int PIPE_DEPTH = ATTR_PIPE_DEPTH
) (
    input  logic                  clk,
    input  logic                  h_reset,
    input  logic                  clk_en,
    input  logic                  pix_valid,
    input  logic [ATTR_IDX_W-1:0] pix_idx,
    input  logic                  pix_de,
    input  logic                  pix_blink,
    input  logic                  vsync,
    input  logic [ATTR_IDX_W-1:0] plane_en,
    input  logic                  mode_8bpp,
    input  logic                  p54s,
    input  logic                  blink_en,
    input  logic [ATTR_IDX_W-1:0] color_sel,
    input  logic [DAC_W-1:0]      overscan,
    output logic [ATTR_IDX_W-1:0] pal_addr,
    input  logic [PAL_W-1:0]      pal_data,
    output logic [DAC_W-1:0]      dac_idx,
    output logic                  dac_valid
);

    localparam int UNUSED_DEPTH = PIPE_DEPTH;

    logic                  blink_phase;
    logic [ATTR_IDX_W-1:0] masked;
    logic                  phase;
    logic [3:0]            held;
    attr_sb_t              sb_a;
    attr_sb_t              sb_b;

`ifdef ATTR_BLINK_EN
    attr_blink_ctr u_blink (
        .clk         (clk),
        .rst         (h_reset),
        .vsync       (vsync),
        .blink_phase (blink_phase)
    );

    always_comb begin
        masked = pix_idx & plane_en;
        if (blink_en & pix_blink & blink_phase)
            masked[3] = 1'b0;
    end
`else
    logic unused_blink;
    assign unused_blink = ^{vsync, pix_blink, blink_en};
    assign blink_phase  = 1'b0;

    always_comb begin
        masked = pix_idx & plane_en;
        if (blink_phase)
            masked[3] = 1'b0;
    end
`endif

    // Stage A: palette address plus sideband. The 8bpp pairing phase
    // toggles on every displayed pixel and restarts on border pixels.
    always_ff @(posedge clk or posedge h_reset) begin
        if (h_reset) begin
            pal_addr <= '0;
            sb_a     <= '0;
            phase    <= 1'b0;
        end else if (clk_en) begin
            sb_a.valid <= pix_valid;
            sb_a.de    <= pix_de;
            sb_a.phase <= phase;
            if (pix_valid) begin
                pal_addr <= masked;
                phase    <= pix_de ? ~phase : 1'b0;
            end
        end
    end

    // Stage B: sideband waits while the palette performs its read.
    always_ff @(posedge clk or posedge h_reset) begin
        if (h_reset)
            sb_b <= '0;
        else if (clk_en)
            sb_b <= sb_a;
    end

    // Stage C: merge palette data into the DAC index.
    always_ff @(posedge clk or posedge h_reset) begin
        if (h_reset) begin
            dac_idx   <= '0;
            dac_valid <= 1'b0;
            held      <= '0;
        end else if (clk_en) begin
            dac_valid <= 1'b0;
            if (sb_b.valid) begin
                if (!sb_b.de) begin
                    dac_idx   <= overscan;
                    dac_valid <= 1'b1;
                end else if (!mode_8bpp) begin
                    dac_idx   <= dac_compose(color_sel, p54s, pal_data);
                    dac_valid <= 1'b1;
                end else if (!sb_b.phase) begin
                    held <= pal_data[3:0];
                end else begin
                    dac_idx   <= {held, pal_data[3:0]};
                    dac_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_attr_pixel_pipe.sv
// Self-checking bench for attr_pixel_pipe: directed steps plus
// randomized traffic against a behavioural model with a palette.
module tb_attr_pixel_pipe;

    logic       clk = 1'b0;
    logic       h_reset = 1'b0;
    logic       clk_en = 1'b0;
    logic       pix_valid = 1'b0;
    logic [3:0] pix_idx = '0;
    logic       pix_de = 1'b0;
    logic       pix_blink = 1'b0;
    logic       vsync = 1'b0;
    logic [3:0] plane_en = 4'hF;
    logic       mode_8bpp = 1'b0;
    logic       p54s = 1'b0;
    logic       blink_en = 1'b0;
    logic [3:0] color_sel = '0;
    logic [7:0] overscan = '0;
    logic [3:0] pal_addr;
    logic [5:0] pal_data;
    logic [7:0] dac_idx;
    logic       dac_valid;

    logic [5:0] pal_mem [16];

    int cmp = 0;
    int bad = 0;

    attr_pixel_pipe #(.PIPE_DEPTH(3)) dut (
        .clk       (clk),
        .h_reset   (h_reset),
        .clk_en    (clk_en),
        .pix_valid (pix_valid),
        .pix_idx   (pix_idx),
        .pix_de    (pix_de),
        .pix_blink (pix_blink),
        .vsync     (vsync),
        .plane_en  (plane_en),
        .mode_8bpp (mode_8bpp),
        .p54s      (p54s),
        .blink_en  (blink_en),
        .color_sel (color_sel),
        .overscan  (overscan),
        .pal_addr  (pal_addr),
        .pal_data  (pal_data),
        .dac_idx   (dac_idx),
        .dac_valid (dac_valid)
    );

    always #5 clk = ~clk;

    // Palette register bank read port, registered on clk_en.
    always @(posedge clk or posedge h_reset) begin
        if (h_reset)
            pal_data <= '0;
        else if (clk_en)
            pal_data <= pal_mem[pal_addr];
    end

    // Reference model: each accepted slot yields an output two
    // clk_en edges later; pairing, blink and holds from the rules.
    typedef struct {
        bit v;
        bit de;
        int addr;
        bit ph;
    } rec_t;

    rec_t       pq[$];
    bit         m_ph;
    int         m_held;
    int         frames;
    bit         m_vs;
    logic [7:0] e_idx;
    logic       e_v;
    logic [3:0] e_addr;

    task automatic model_rst();
        rec_t z;
        z = '{v: 0, de: 0, addr: 0, ph: 0};
        pq = {z, z};
        m_ph = 0;
        m_held = 0;
        frames = 0;
        m_vs = 0;
        e_idx = '0;
        e_v = 1'b0;
        e_addr = '0;
    endtask

    task automatic model_edge();
        rec_t r;
        rec_t n;
        int   pal;
        int   a;
        if (h_reset) begin
            model_rst();
            return;
        end
        if (vsync && !m_vs)
            frames++;
        m_vs = vsync;
        if (!clk_en)
            return;
        r = pq.pop_front();
        e_v = 1'b0;
        if (r.v) begin
            pal = int'(pal_mem[r.addr]);
            if (!r.de) begin
                e_idx = overscan;
                e_v = 1'b1;
            end else if (!mode_8bpp) begin
                e_idx = 8'((color_sel / 4) * 64
                    + (p54s ? color_sel % 4 : pal / 16) * 16
                    + pal % 16);
                e_v = 1'b1;
            end else if (!r.ph) begin
                m_held = pal % 16;
            end else begin
                e_idx = 8'(m_held * 16 + pal % 16);
                e_v = 1'b1;
            end
        end
        n = '{v: pix_valid, de: pix_de, addr: 0, ph: m_ph};
        if (pix_valid) begin
            a = int'(pix_idx & plane_en);
`ifdef ATTR_BLINK_EN
            if (blink_en && pix_blink && ((frames / 16) % 2 == 1))
                a = a % 8;
`endif
            n.addr = a;
            e_addr = 4'(a);
            m_ph = pix_de ? !m_ph : 1'b0;
        end
        pq.push_back(n);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        cmp++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("dac_valid", {7'b0, dac_valid}, {7'b0, e_v});
        chk("dac_idx", dac_idx, e_idx);
        chk("pal_addr", {4'b0, pal_addr}, {4'b0, e_addr});
        @(negedge clk);
    endtask

    task automatic pix(input logic v, input logic [3:0] idx,
                       input logic de);
        pix_valid = v;
        pix_idx = idx;
        pix_de = de;
    endtask

    initial begin
        logic [3:0] blink_exp;
        for (int i = 0; i < 16; i++)
            pal_mem[i] = 6'($urandom);
        pal_mem[4'hA] = 6'h2B;
        pal_mem[4'h1] = 6'h0C;
        pal_mem[4'h2] = 6'h03;
        pal_mem[4'hC] = 6'h15;
        pal_mem[4'h4] = 6'h2E;

        #2;
        h_reset = 1'b1;
        clk_en = 1'b1;
        pix(1'b1, 4'hA, 1'b1);
        color_sel = 4'h4;
        @(negedge clk);
        step();
        step();
        chk("rst_dac_idx", dac_idx, 8'h00);
        chk("rst_dac_valid", {7'b0, dac_valid}, 8'h00);
        chk("rst_pal_addr", {4'b0, pal_addr}, 8'h00);

        // First pixel after release, latency of three edges.
        h_reset = 1'b0;
        step();
        chk("lat_e1_valid", {7'b0, dac_valid}, 8'h00);
        step();
        chk("lat_e2_valid", {7'b0, dac_valid}, 8'h00);
        step();
        chk("lat_e3_valid", {7'b0, dac_valid}, 8'h01);
        chk("lat_e3_idx", dac_idx, 8'h6B);

        p54s = 1'b1;
        color_sel = 4'h7;
        repeat (3) step();
        chk("p54s_idx", dac_idx, 8'h7B);

        plane_en = 4'h3;
        step();
        chk("plane_addr", {4'b0, pal_addr}, 8'h02);
        plane_en = 4'hF;

        pix(1'b1, 4'hA, 1'b0);
        overscan = 8'h55;
        repeat (3) step();
        chk("overscan_idx", dac_idx, 8'h55);
        chk("overscan_valid", {7'b0, dac_valid}, 8'h01);

        // 256-colour pair after a border pixel restarts pairing.
        mode_8bpp = 1'b1;
        step();
        pix(1'b1, 4'h1, 1'b1);
        step();
        pix(1'b1, 4'h2, 1'b1);
        step();
        pix(1'b0, 4'h0, 1'b1);
        step();
        chk("pair_first_valid", {7'b0, dac_valid}, 8'h00);
        step();
        chk("pair_idx", dac_idx, 8'hC3);
        chk("pair_valid", {7'b0, dac_valid}, 8'h01);
        step();

        // Randomized traffic with a 5-cycle clk_en stall midway.
        for (int i = 0; i < 400; i++) begin
            pix(1'($urandom), 4'($urandom), ($urandom_range(0, 5) != 0));
            pix_blink = 1'($urandom);
            blink_en = 1'($urandom);
            vsync = ($urandom_range(0, 5) == 0);
            plane_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            if ($urandom_range(0, 15) == 0)
                mode_8bpp = ~mode_8bpp;
            p54s = 1'($urandom);
            color_sel = 4'($urandom);
            overscan = 8'($urandom);
            clk_en = (i >= 200 && i < 205) ? 1'b0
                                           : ($urandom_range(0, 3) != 0);
            step();
        end

        // Reset with pixels in flight.
        clk_en = 1'b1;
        vsync = 1'b0;
        mode_8bpp = 1'b0;
        pix(1'b1, 4'h5, 1'b1);
        step();
        h_reset = 1'b1;
        step();
        h_reset = 1'b0;
        step();
        chk("rst_mid_e1", {7'b0, dac_valid}, 8'h00);
        step();
        chk("rst_mid_e2", {7'b0, dac_valid}, 8'h00);
        step();

        // Blink: 16 frames turn plane 3 off, 16 more turn it back on.
        blink_en = 1'b1;
        pix_blink = 1'b1;
        plane_en = 4'hF;
        pix(1'b1, 4'hC, 1'b1);
        step();
        chk("blink_f0", {4'b0, pal_addr}, 8'h0C);
`ifdef ATTR_BLINK_EN
        blink_exp = 4'h4;
`else
        blink_exp = 4'hC;
`endif
        for (int f = 0; f < 32; f++) begin
            clk_en = 1'b0;
            vsync = 1'b1;
            step();
            vsync = 1'b0;
            step();
            if (f == 15) begin
                clk_en = 1'b1;
                step();
                chk("blink_f16", {4'b0, pal_addr}, {4'b0, blink_exp});
            end
        end
        clk_en = 1'b1;
        step();
        chk("blink_f32", {4'b0, pal_addr}, 8'h0C);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
